// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS subset core with integrated instruction/data memories
// Ports: clk, reset (async, active-high); run starts/continues execution; prog_we/prog_addr/prog_data
// write instruction memory while IDLE; pc, instruction, reg_t0..reg_t3, alu_result, zero, mem_read_data
// and state expose the datapath; retired counts completed instructions; halted/trap report HALT and
// whether it was entered through a fault.
module mips_multicycle_core #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    output logic [31:0]                   pc,
    output logic [31:0]                   instruction,
    output logic [31:0]                   reg_t0,
    output logic [31:0]                   reg_t1,
    output logic [31:0]                   reg_t2,
    output logic [31:0]                   reg_t3,
    output logic [31:0]                   alu_result,
    output logic                          zero,
    output logic [31:0]                   mem_read_data,
    output logic [2:0]                    state,
    output logic [31:0]                   retired,
    output logic                          halted,
    output logic                          trap
);
    localparam int          IA         = $clog2(IMEM_DEPTH);
    localparam int          DA         = $clog2(DMEM_DEPTH);
    localparam logic [29:0] IMEM_WORDS = 30'(IMEM_DEPTH);
    localparam logic [29:0] DMEM_WORDS = 30'(DMEM_DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6;

    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR  = 6'h25, FN_SLT = 6'h2A;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];
    logic [31:0] rf   [32];

    logic [2:0]  next_state, end_state;
    logic [5:0]  opcode, funct, alu_fn;
    logic [4:0]  rs, rt, rd, wb_reg;
    logic [31:0] imm_sext, rs_val, rt_val, alu_a, alu_b, alu_y, wb_data;
    logic        is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, is_syscall, legal;
    logic        fetch_fault, mem_fault;
    logic        ir_load, alu_load, pc_branch, pc_jump, mdr_load, rf_write, dmem_write;
    logic        retire, trap_set;

    assign opcode   = instruction[31:26];
    assign rs       = instruction[25:21];
    assign rt       = instruction[20:16];
    assign rd       = instruction[15:11];
    assign funct    = instruction[5:0];
    assign imm_sext = {{16{instruction[15]}}, instruction[15:0]};
    assign rs_val   = rf[rs];
    assign rt_val   = rf[rt];

    assign is_syscall = (instruction == 32'h0000_000C);
    assign is_rtype   = (opcode == 6'h00) && (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
    assign is_addi    = (opcode == 6'h08);
    assign is_lw      = (opcode == 6'h23);
    assign is_sw      = (opcode == 6'h2B);
    assign is_beq     = (opcode == 6'h04);
    assign is_j       = (opcode == 6'h02);
    assign legal      = is_rtype || is_addi || is_lw || is_sw || is_beq || is_j;

    // One shared ALU: pc+4 by default (FETCH), branch target in DECODE, instruction op in EXEC.
    always_comb begin
        alu_a  = pc;
        alu_b  = 32'd4;
        alu_fn = FN_ADD;
        if (state == S_DECODE) begin
            alu_b = {imm_sext[29:0], 2'b00};
        end else if (state == S_EXEC) begin
            alu_a = rs_val;
            alu_b = (is_rtype || is_beq) ? rt_val : imm_sext;
            if (is_rtype)    alu_fn = funct;
            else if (is_beq) alu_fn = FN_SUB;
        end
    end

    always_comb begin
        case (alu_fn)
            FN_SUB:  alu_y = alu_a - alu_b;
            FN_AND:  alu_y = alu_a & alu_b;
            FN_OR:   alu_y = alu_a | alu_b;
            FN_SLT:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    assign zero        = (alu_y == 32'd0);
    assign fetch_fault = (pc[1:0] != 2'b00) || (pc[31:2] >= IMEM_WORDS);
    assign mem_fault   = (alu_y[1:0] != 2'b00) || (alu_y[31:2] >= DMEM_WORDS);
    assign end_state   = run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (run) next_state = S_FETCH;
            S_FETCH:  next_state = fetch_fault ? S_HALT : S_DECODE;
            S_DECODE: next_state = (is_syscall || !legal) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (is_lw || is_sw)      next_state = mem_fault ? S_HALT : S_MEM;
                else if (is_beq || is_j) next_state = end_state;
                else                     next_state = S_WB;
            end
            S_MEM:    next_state = is_lw ? S_WB : end_state;
            S_WB:     next_state = end_state;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ir_load    = 1'b0;
        alu_load   = 1'b0;
        pc_branch  = 1'b0;
        pc_jump    = 1'b0;
        mdr_load   = 1'b0;
        rf_write   = 1'b0;
        dmem_write = 1'b0;
        retire     = 1'b0;
        trap_set   = 1'b0;
        case (state)
            S_FETCH: begin
                if (fetch_fault) trap_set = 1'b1;
                else             ir_load  = 1'b1;
            end
            S_DECODE: begin
                alu_load = 1'b1;
                if (is_syscall)  retire   = 1'b1;
                else if (!legal) trap_set = 1'b1;
            end
            S_EXEC: begin
                if (is_rtype || is_addi) begin
                    alu_load = 1'b1;
                end else if (is_lw || is_sw) begin
                    alu_load = 1'b1;
                    trap_set = mem_fault;
                end else if (is_beq) begin
                    pc_branch = zero;
                    retire    = 1'b1;
                end else begin
                    pc_jump = 1'b1;
                    retire  = 1'b1;
                end
            end
            S_MEM: begin
                if (is_lw) begin
                    mdr_load = 1'b1;
                end else begin
                    dmem_write = 1'b1;
                    retire     = 1'b1;
                end
            end
            S_WB: begin
                rf_write = 1'b1;
                retire   = 1'b1;
            end
            default: ;
        endcase
    end

    assign wb_reg  = is_rtype ? rd : rt;
    assign wb_data = is_lw ? mem_read_data : alu_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_PC;
            instruction   <= 32'd0;
            alu_result    <= 32'd0;
            mem_read_data <= 32'd0;
            retired       <= 32'd0;
            trap          <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else begin
            if (ir_load) begin
                instruction <= imem[pc[IA+1:2]];
                pc          <= alu_y;
            end
            if (alu_load)  alu_result    <= alu_y;
            if (pc_branch) pc            <= alu_result;
            if (pc_jump)   pc            <= {pc[31:28], instruction[25:0], 2'b00};
            if (mdr_load)  mem_read_data <= dmem[alu_result[DA+1:2]];
            // Register 0 is never written, so it keeps its reset value of zero.
            if (rf_write && wb_reg != 5'd0) rf[wb_reg] <= wb_data;
            if (retire)    retired       <= retired + 32'd1;
            if (trap_set)  trap          <= 1'b1;
        end
    end

    // Memories hold their contents across reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && prog_we) imem[prog_addr] <= prog_data;
        if (dmem_write) dmem[alu_result[DA+1:2]] <= rt_val;
    end

    assign reg_t0 = rf[8];
    assign reg_t1 = rf[9];
    assign reg_t2 = rf[10];
    assign reg_t3 = rf[11];
    assign halted = (state == S_HALT);
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - self-checking bench for mips_multicycle_core
module tb_mips_multicycle_core;
    logic        clk = 1'b0;
    logic        reset, run, prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] pc, instruction, reg_t0, reg_t1, reg_t2, reg_t3, alu_result, mem_read_data, retired;
    logic        zero, halted, trap;
    logic [2:0]  state;

    mips_multicycle_core dut (
        .clk(clk), .reset(reset), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .pc(pc), .instruction(instruction), .reg_t0(reg_t0),
        .reg_t1(reg_t1), .reg_t2(reg_t2), .reg_t3(reg_t3), .alu_result(alu_result),
        .zero(zero), .mem_read_data(mem_read_data), .state(state), .retired(retired),
        .halted(halted), .trap(trap)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] mimem [256];
    logic [31:0] mdmem [256];
    logic [31:0] mreg  [32];
    logic [31:0] m_pc, m_ret;
    logic        m_trap;
    int          m_cyc;
    logic [31:0] prog [$];
    int          tr_state [$];
    logic [31:0] tr_t0 [$];
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [4:0] rr();
        int r;
        r = int'($urandom_range(0, 4));
        return (r == 0) ? 5'd0 : 5'(7 + r);
    endfunction

    // Instruction-level interpreter: architectural effect plus cycle cost per instruction.
    task automatic model_run();
        logic [31:0] ins, a, b, imm, v, addr;
        logic [4:0]  d;
        logic        wr, bad;
        int          lat;
        foreach (mreg[r]) mreg[r] = 32'd0;
        m_pc = 32'h0; m_ret = 32'd0; m_trap = 1'b0; m_cyc = 1;
        for (int step = 0; step < 4000; step++) begin
            if (m_pc[1:0] != 2'b00 || m_pc >= 32'd1024) begin
                m_trap = 1'b1; m_cyc += 1; return;
            end
            ins = mimem[m_pc[9:2]];
            m_pc += 32'd4;
            if (ins == 32'h0000_000C) begin
                m_ret++; m_cyc += 2; return;
            end
            a = mreg[ins[25:21]]; b = mreg[ins[20:16]];
            imm = {{16{ins[15]}}, ins[15:0]};
            wr = 1'b0; bad = 1'b0; d = ins[20:16]; v = 32'd0; lat = 0;
            case (ins[31:26])
                6'h00: begin
                    d = ins[15:11]; wr = 1'b1; lat = 4;
                    case (ins[5:0])
                        6'h20: v = a + b;
                        6'h22: v = a - b;
                        6'h24: v = a & b;
                        6'h25: v = a | b;
                        6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: bad = 1'b1;
                    endcase
                end
                6'h08: begin v = a + imm; wr = 1'b1; lat = 4; end
                6'h23, 6'h2B: begin
                    addr = a + imm;
                    if (addr[1:0] != 2'b00 || addr >= 32'd1024) begin
                        m_trap = 1'b1; m_cyc += 3; return;
                    end
                    if (ins[31:26] == 6'h23) begin
                        v = mdmem[addr[9:2]]; wr = 1'b1; lat = 5;
                    end else begin
                        mdmem[addr[9:2]] = b; lat = 4;
                    end
                end
                6'h04: begin
                    if (a == b) m_pc = m_pc + (imm << 2);
                    lat = 3;
                end
                6'h02: begin m_pc = {m_pc[31:28], ins[25:0], 2'b00}; lat = 3; end
                default: bad = 1'b1;
            endcase
            if (bad) begin
                m_trap = 1'b1; m_cyc += 2; return;
            end
            if (wr && d != 5'd0) mreg[d] = v;
            m_cyc += lat;
            m_ret++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; prog_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic load();
        foreach (prog[i]) begin
            prog_we = 1'b1; prog_addr = 8'(i); prog_data = prog[i];
            mimem[i] = prog[i];
            @(negedge clk);
        end
        prog_we = 1'b0;
    endtask

    task automatic run_to_halt(input int maxc);
        tr_state.delete(); tr_t0.delete(); cyc = 0;
        run = 1'b1;
        while (!halted && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            tr_state.push_back(int'(state));
            tr_t0.push_back(reg_t0);
        end
        run = 1'b0;
        chk("halted", 32'(halted), 32'd1);
    endtask

    task automatic check_final(input string lbl);
        chk({lbl, ".t0"}, reg_t0, mreg[8]);
        chk({lbl, ".t1"}, reg_t1, mreg[9]);
        chk({lbl, ".t2"}, reg_t2, mreg[10]);
        chk({lbl, ".t3"}, reg_t3, mreg[11]);
        chk({lbl, ".pc"}, pc, m_pc);
        chk({lbl, ".retired"}, retired, m_ret);
        chk({lbl, ".trap"}, 32'(trap), 32'(m_trap));
        chk({lbl, ".cycles"}, 32'(cyc), 32'(m_cyc));
    endtask

    task automatic gen_random(input int n);
        logic [5:0] fns [5];
        int k, off;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        prog.delete();
        for (int i = 0; i < n - 1; i++) begin
            k = int'($urandom_range(0, 99));
            if (k < 35)      prog.push_back(enc_r(rr(), rr(), rr(), fns[$urandom_range(0, 4)]));
            else if (k < 55) prog.push_back(enc_i(6'h08, rr(), rr(), 16'($urandom)));
            else if (k < 68) prog.push_back(enc_i(6'h2B, 5'd0, rr(), 16'($urandom_range(0, 15) * 4)));
            else if (k < 80) prog.push_back(enc_i(6'h23, 5'd0, rr(), 16'($urandom_range(0, 15) * 4)));
            else if (k < 88) begin
                off = int'($urandom_range(0, n - 2 - i));
                prog.push_back(enc_i(6'h04, rr(), rr(), 16'(off)));
            end else if (k < 93) prog.push_back({6'h02, 26'($urandom_range(i + 1, n - 1))});
            else if (k < 96) prog.push_back(32'hFC00_0000);
            else prog.push_back(enc_i(6'h23, 5'd0, rr(), 16'($urandom_range(0, 15) * 4 + 2)));
        end
        prog.push_back(32'h0000_000C);
    endtask

    initial begin
        int first_f, sub_cnt;
        logic found;
        reset = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = 8'd0; prog_data = 32'd0;
        #1 reset = 1'b1;
        #1;
        chk("rst.state_async", 32'(state), 32'd0);
        chk("rst.pc_async", pc, 32'd0);
        do_reset();
        chk("rst.ir", instruction, 32'd0);
        chk("rst.alu", alu_result, 32'd0);
        chk("rst.mdr", mem_read_data, 32'd0);
        chk("rst.retired", retired, 32'd0);
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.trap", 32'(trap), 32'd0);
        chk("rst.t0", reg_t0, 32'd0);

        // Arithmetic program with timing of the add and sub results.
        prog = '{32'h2009_0005, 32'h200A_000A, 32'h012A_4020, 32'h012A_4022,
                 32'h012A_4024, 32'h012A_4025, 32'h0000_000C};
        load();
        model_run();
        run_to_halt(200);
        check_final("p1");
        chk("p1.t0_const", reg_t0, 32'h0000_000F);
        chk("p1.t1_const", reg_t1, 32'd5);
        chk("p1.t2_const", reg_t2, 32'd10);
        chk("p1.pc_const", pc, 32'h1C);
        chk("p1.retired_const", retired, 32'd7);
        first_f = -1; sub_cnt = 0;
        foreach (tr_t0[i]) begin
            if (first_f < 0 && tr_t0[i] == 32'h0000_000F) first_f = i;
            if (tr_t0[i] == 32'hFFFF_FFFB) sub_cnt++;
        end
        chk("p1.add_latency", 32'(first_f), 32'd12);
        chk("p1.sub_hold", 32'(sub_cnt), 32'd4);

        // Asynchronous reset while in EXEC, then rerun the retained program.
        do_reset();
        run = 1'b1; found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (state == 3'd3 && retired == 32'd2) found = 1'b1;
        end
        chk("rstx.reach_exec", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstx.state", 32'(state), 32'd0);
        chk("rstx.pc", pc, 32'd0);
        chk("rstx.t1", reg_t1, 32'd0);
        chk("rstx.retired", retired, 32'd0);
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_to_halt(200);
        check_final("rerun");

        // Drop run during the add's second cycle.
        do_reset();
        run = 1'b1;
        repeat (10) @(negedge clk);
        chk("drop.in_decode", 32'(state), 32'd2);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("drop.idle", 32'(state), 32'd0);
        chk("drop.retired", retired, 32'd3);
        chk("drop.t0", reg_t0, 32'h0000_000F);
        repeat (3) @(negedge clk);
        chk("drop.still_idle", 32'(state), 32'd0);
        chk("drop.still_retired", retired, 32'd3);

        // prog_we during FETCH is ignored; in IDLE it lands.
        run = 1'b1;
        @(negedge clk);
        chk("pw.fetch", 32'(state), 32'd1);
        prog_we = 1'b1; prog_addr = 8'd6; prog_data = 32'hFC00_0000;
        @(negedge clk);
        prog_we = 1'b0;
        run_to_halt(200);
        chk("pw.fetch_trap", 32'(trap), 32'd0);
        chk("pw.fetch_retired", retired, 32'd7);
        chk("pw.fetch_pc", pc, 32'h1C);
        do_reset();
        prog_we = 1'b1; prog_addr = 8'd6; prog_data = 32'hFC00_0000;
        mimem[6] = 32'hFC00_0000;
        @(negedge clk);
        prog_we = 1'b0;
        model_run();
        run_to_halt(200);
        check_final("pw.idle");
        chk("pw.idle_trap", 32'(trap), 32'd1);

        // Store then load through data memory.
        do_reset();
        prog = '{32'h200A_000A, 32'hAC0A_0004, 32'h8C0B_0004, 32'h0000_000C};
        load();
        model_run();
        run_to_halt(200);
        check_final("lwsw");
        chk("lwsw.t3", reg_t3, 32'h0000_000A);
        chk("lwsw.mdr", mem_read_data, 32'h0000_000A);
        chk("lwsw.exec", 32'(tr_state[10]), 32'd3);
        chk("lwsw.mem", 32'(tr_state[11]), 32'd4);
        chk("lwsw.wb", 32'(tr_state[12]), 32'd5);
        chk("lwsw.next_fetch", 32'(tr_state[13]), 32'd1);

        // beq taken and not taken.
        do_reset();
        prog = '{32'h2009_0005, 32'h200A_0005, 32'h112A_0001, 32'h2008_0007, 32'h0000_000C};
        load();
        model_run();
        run_to_halt(200);
        check_final("beq_t");
        chk("beq_t.t0", reg_t0, 32'd0);
        chk("beq_t.cycles", 32'(cyc), 32'd14);
        do_reset();
        prog = '{32'h2009_0005, 32'h200A_0006, 32'h112A_0001, 32'h2008_0007, 32'h0000_000C};
        load();
        model_run();
        run_to_halt(200);
        check_final("beq_n");
        chk("beq_n.t0", reg_t0, 32'd7);

        // Fault paths.
        do_reset();
        prog = '{32'hFC00_0000};
        load(); model_run(); run_to_halt(100);
        check_final("ill");
        chk("ill.trap", 32'(trap), 32'd1);
        chk("ill.pc", pc, 32'h4);
        chk("ill.retired", retired, 32'd0);
        do_reset();
        prog = '{32'h8C0B_0402, 32'h0000_000C};
        load(); model_run(); run_to_halt(100);
        check_final("lwmis");
        chk("lwmis.trap", 32'(trap), 32'd1);
        do_reset();
        prog = '{32'h0800_0100};
        load(); model_run(); run_to_halt(100);
        check_final("jfar");
        chk("jfar.pc", pc, 32'h400);
        chk("jfar.trap", 32'(trap), 32'd1);

        // Give data memory known contents, then random programs.
        do_reset();
        prog.delete();
        for (int k = 0; k < 16; k++) prog.push_back(enc_i(6'h2B, 5'd0, 5'd0, 16'(k * 4)));
        prog.push_back(32'h0000_000C);
        load(); model_run(); run_to_halt(200);
        check_final("dinit");
        for (int p = 0; p < 30; p++) begin
            gen_random(int'($urandom_range(6, 14)));
            do_reset();
            load();
            model_run();
            run_to_halt(400);
            check_final($sformatf("rnd%0d", p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS core, with the same ISA subset and the same debug outputs. Instructions execute over 2-5 states of a control FSM with one shared ALU. The block adds:
- integrated instruction and data memories of configurable depth;
- a program-load port and a run handshake;
- halt/trap detection;
- a retired-instruction counter.

Parameters:
IMEM_DEPTH, 256, instruction memory depth in 32-bit words (power of two)
DMEM_DEPTH, 256, data memory depth in 32-bit words (power of two)
RESET_PC, 32'h0, PC value loaded at reset (word-aligned)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  start/continue execution; sampled in IDLE and at each instruction end
prog_we  in  1  instruction-memory write strobe; honoured only in IDLE
prog_addr  in  $clog2(IMEM_DEPTH)  imem word address
prog_data  in  32  imem write data
pc  out  32  program counter register
instruction  out  32  instruction register (IR)
reg_t0, reg_t1, reg_t2, reg_t3  out  32 each  registers 8..11
alu_result  out  32  registered ALU output (ALUOut)
zero  out  1  ALU zero flag, combinational from current ALU operands
mem_read_data  out  32  memory data register (MDR)
state  out  3  FSM state encoding
retired  out  32  retired-instruction count
halted  out  1  core is in HALT
trap  out  1  HALT was entered through a fault

Behaviour:
- Reset (asynchronous, immediate, mid-instruction included):
  - pc=RESET_PC; IR, ALUOut, MDR = 0; all 32 GPRs = 0; retired = 0; state = IDLE; halted = trap = 0.
  - imem and dmem contents are NOT cleared.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE:
  - prog_we writes imem[prog_addr] at the clock edge.
  - run=1 -> FETCH.
  - prog_we in any other state is ignored.
- FETCH:
  - If pc[1:0]!=0 or pc>>2 >= IMEM_DEPTH -> HALT with trap=1; pc unchanged.
  - Otherwise IR <= imem[pc>>2], pc <= pc+4, then DECODE.
- DECODE:
  - Reads rs/rt and computes branch target = pc + (sext(imm16)<<2) into ALUOut.
  - 0x0000000C (syscall) -> HALT, trap=0, retired += 1.
  - Unsupported opcode/funct -> HALT, trap=1.
  - Otherwise EXEC.
- Supported instructions:
  - R-type add(20h), sub(22h), and(24h), or(25h), slt(2Ah).
  - addi(08h), lw(23h), sw(2Bh), beq(04h), j(02h).
- EXEC:
  - R-type: ALUOut <= rs op rt, then WB.
  - addi: ALUOut <= rs + sext(imm), then WB.
  - lw/sw: ALUOut <= rs + sext(imm). If the address is misaligned or the word index >= DMEM_DEPTH -> HALT with trap=1. Otherwise MEM.
  - beq: if rs==rt, pc <= ALUOut. Instruction ends.
  - j: pc <= {pc[31:28], IR[25:0], 2'b00}. Instruction ends.
- MEM:
  - lw: MDR <= dmem[ALUOut>>2], then WB.
  - sw: dmem[ALUOut>>2] <= rt. Instruction ends.
- WB:
  - R-type writes rd; addi writes rt with ALUOut; lw writes rt with MDR. Instruction ends.
  - Writes to register 0 are discarded; reg 0 always reads 0.
- Latencies in cycles:
  - R-type / addi: 4
  - lw: 5
  - sw: 4
  - beq / j: 3
- Instruction end:
  - retired += 1, wrapping modulo 2^32.
  - Next state is FETCH if run=1, otherwise IDLE.
  - Deasserting run mid-instruction never aborts that instruction.
- Arithmetic: two's complement, overflow ignored (add/addi do not trap). slt is a signed compare; result is 1 or 0.
- HALT: halted=1. Leaves only via reset. pc holds faulting address+4 for a DECODE/EXEC trap, or the faulting address for a FETCH trap.

Test Plan:
- Load program 20090005, 200A000A, 012A4020, 012A4022, 012A4024, 012A4025, 0000000C; pulse run; wait for halted -> t1=5, t2=10, t0=0x0000000F, trap=0, retired=7, pc=0x1C; add done 12 cycles after run sampled; sub leaves t0=0xFFFFFFFB for exactly 4 cycles.
- Load addi $t2,0,10; sw $t2,4($zero) (AC0A0004); lw $t3,4($zero) (8C0B0004); syscall -> t3=0x0000000A, MDR=0xA, lw spends exactly one cycle each in MEM and WB, retired=4.
- Load beq $t1,$t2 with t1=t2=5 and offset 1, followed by a skipped addi $t0 -> t0 stays 0, beq takes 3 cycles. Repeat with t1!=t2 -> addi executes.
- Load illegal word FC000000 at 0 -> halted=1, trap=1, pc=0x4, retired=0. lw from 0x402 -> trap. j to address >= IMEM_DEPTH*4 -> FETCH trap with pc = target.
- Assert reset between clock edges while in EXEC -> state=0, pc=RESET_PC, regs/retired 0 with no clock edge; imem program intact, rerun gives identical results.
- Drop run during the 2nd cycle of add -> add completes, state goes to IDLE, retired=+1. prog_we pulsed during FETCH leaves imem unchanged; pulsed in IDLE updates it.
